goc_frame_tx: RTL and testbench
===============================

# goc_frame_tx

Slave on the ICE master/slave bus that consumes host frames addressed to the GOC event type, buffers the payload, and serialises it Manchester-encoded onto the GOC optical pad at the programmed rate. It sits downstream of the bus controller, alongside the EIN and PMU slaves. It takes `goc_speed`/`goc_polarity` from the basics block. After each frame it arbitrates for the slave bus and returns an ACK or NAK word.

## Interface
- `EVT_ADDR`, default 8'h67 ('g'): ma_addr value this block accepts.
- `FIFO_DEPTH`, default 64: payload byte capacity (power of two).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ma_addr` in 8: event type of the current frame.
- `ma_data` in 8: payload byte.
- `ma_data_valid` in 1: one-cycle strobe per byte.
- `ma_frame_valid` in 1: high for the whole frame.
- `sl_overflow` out 1: one-cycle pulse when an accepted-address byte is dropped.
- `goc_speed` in 32: half-bit period in clk cycles; 0 is treated as 1.
- `goc_polarity` in 1: pad level meaning "light off".
- `goc_pad` out 1: GOC LED drive.
- `sl_arb_request` out 1: slave bus request.
- `sl_arb_grant` in 1: slave bus grant.
- `sl_addr` out 9: response address; bit 8 is the valid flag.
- `sl_data` out 9: response data; bit 8 is the valid flag.
- `sl_tail` out 9: response tail word.
- `sl_latch_tail` out 1: tail strobe.
- `busy` out 1: high in every state except IDLE.

## Operation
- Slave-bus outputs (`sl_addr`, `sl_data`, `sl_tail`, `sl_latch_tail`) are 0 except in the granted response cycles, because the top level OR-combines them.
- Reset values:
  - `goc_pad`=0.
  - All sl_* outputs=0.
  - `sl_overflow`=0, `busy`=0.
  - FIFO empty, state IDLE.
- **IDLE:** `goc_pad`=`goc_polarity`. On a rising `ma_frame_valid` with `ma_addr`==EVT_ADDR, go to RX and clear the byte count and error flag. Frames with any other address are ignored.
- **RX:**
  - Each `ma_data_valid` writes `ma_data` to the FIFO and increments `count` (8 bits, saturating at FIFO_DEPTH).
  - A write while the FIFO is full drops the byte, pulses `sl_overflow`, and sets the error flag.
  - On a falling `ma_frame_valid`: if the error flag is set, flush the FIFO and go to RESP. Otherwise, if the FIFO is empty go to RESP; else go to TX.
- **TX:**
  - Bytes go out MSB first. Each bit occupies two half-bits of `max(goc_speed,1)` clk cycles each.
  - Bit 1 drives `goc_pad` = ~polarity then polarity; bit 0 drives polarity then ~polarity.
  - After the last half-bit of the last byte, `goc_pad` returns to polarity and the state moves to RESP.
  - `goc_speed`/`goc_polarity` are sampled at the start of each half-bit, so a change mid-frame takes effect at the next half-bit.
- **RESP:**
  - Raise `sl_arb_request` and hold it until grant.
  - First granted cycle: `sl_addr`={1, 8'h00 ACK | 8'h01 NAK}, `sl_data`={1, count}.
  - Next cycle: `sl_latch_tail`=1, `sl_tail`={1, 8'h00}, drop the request, go to IDLE.
  - A grant not preceded by a request is ignored.
- **Busy handling:** A new EVT_ADDR frame arriving in TX or RESP is not accepted. Each of its bytes pulses `sl_overflow`, and no response is generated for it.
- **Reset mid-operation:** Reset in any state returns the block to its reset values on the next edge. The FIFO is flushed and no response is sent.

## Timing
- `ma_*` inputs are registered, so FIFO write latency is 1 cycle.
- The first TX half-bit starts 2 cycles after `ma_frame_valid` is sampled low.
- TX duration = bytes × 16 × max(goc_speed,1) cycles.
- `sl_arb_request` rises on the cycle after TX ends, or 2 cycles after frame end for an empty or errored frame.
- Response: one data cycle plus one tail cycle after grant.
- `sl_overflow` is asserted in the cycle after the offending `ma_data_valid`.
- Simultaneous last `ma_data_valid` and `ma_frame_valid` fall: the byte is accepted.

## Structure
- A shared package holds the ACK/NAK codes, the default EVT_ADDR, and the state encoding (IDLE, RX, TX, RESP_REQ, RESP_DATA, RESP_TAIL).
- The FIFO is the existing `fifo` sub-module, parameterised (8, log2 FIFO_DEPTH).
- The Manchester bit timer lives in the top FSM; it is not a separate sub-module.

## Test plan
- **Single byte:** goc_speed=4, polarity=0, frame 'g' with byte 8'hA5 → pad pattern 10 01 10 01 01 10 01 10 with half-bits of 4 cycles, 64 cycles total; then ACK with sl_data=9'h101.
- **Full buffer:** 64 bytes 8'h00..8'h3F → all bytes transmitted in order; ACK with count 64.
- **Overflow:** 65 bytes → one `sl_overflow` pulse, no pad activity, NAK with count 64.
- **Wrong address and busy:** a frame with address 8'h65 → no response. A 'g' frame sent during TX → `sl_overflow` pulses per byte and only one ACK is returned.
- **Empty frame and delayed grant:** empty 'g' frame → ACK with count 0. Grant delayed 10 cycles → `sl_arb_request` held high and sl_* outputs stay 0 until grant.
- **Reset mid-TX and speed 0:** reset asserted mid-TX → `goc_pad`=0, `busy`=0, no response. Then goc_speed=0 → half-bit of 1 cycle.

Source files
------------

// File: rtl/goc_frame_tx_pkg.sv
// Shared definitions for the GOC frame transmitter: response codes, default
// event address and FSM state encoding.
package goc_frame_tx_pkg;

    localparam logic [7:0] DEFAULT_EVT_ADDR = 8'h67;
    localparam logic [7:0] ACK_CODE         = 8'h00;
    localparam logic [7:0] NAK_CODE         = 8'h01;
    localparam logic [7:0] TAIL_CODE        = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_TX,
        ST_RESP_REQ,
        ST_RESP_DATA,
        ST_RESP_TAIL
    } state_t;

    // A programmed speed of zero still gives a one-cycle half-bit.
    function automatic logic [31:0] half_bit_cycles(input logic [31:0] speed);
        return (speed == 32'd0) ? 32'd1 : speed;
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous show-ahead FIFO with flush; depth is 2**ADDR_W entries.
// rd_data always presents the oldest entry while the FIFO is not empty.
module fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [2**ADDR_W];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;

    // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

endmodule

// File: rtl/goc_frame_tx.sv
// GOC frame transmitter: buffers host frames for EVT_ADDR, sends them
// Manchester-encoded on the GOC pad, then returns ACK/NAK on the slave bus.
module goc_frame_tx
    import goc_frame_tx_pkg::*;
#(
    parameter logic [7:0] EVT_ADDR   = DEFAULT_EVT_ADDR,
    parameter int         FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ma_addr,
    input  logic [7:0]  ma_data,
    input  logic        ma_data_valid,
    input  logic        ma_frame_valid,
    output logic        sl_overflow,
    input  logic [31:0] goc_speed,
    input  logic        goc_polarity,
    output logic        goc_pad,
    output logic        sl_arb_request,
    input  logic        sl_arb_grant,
    output logic [8:0]  sl_addr,
    output logic [8:0]  sl_data,
    output logic [8:0]  sl_tail,
    output logic        sl_latch_tail,
    output logic        busy
);

    localparam int         ADDR_W    = $clog2(FIFO_DEPTH);
    localparam logic [7:0] COUNT_SAT = 8'((FIFO_DEPTH > 255) ? 255 : FIFO_DEPTH);

    state_t      state, state_next;
    logic [7:0]  addr_q, data_q;
    logic        dv_q, fv_q, fv_qq;
    logic [7:0]  count;
    logic        err;
    logic        busy_frame;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic        half;
    logic [31:0] timer;
    logic        pad;

    logic        frame_rise, frame_fall, addr_hit, in_busy_state, start;
    logic        rx_drop, busy_drop, err_now;
    logic        byte_done, tx_done;
    logic        fifo_wr, fifo_rd, fifo_flush, fifo_empty, fifo_full;
    logic [7:0]  fifo_rd_data;
    logic [31:0] hb_reload;

    assign frame_rise    = fv_q && !fv_qq;
    assign frame_fall    = !fv_q && fv_qq;
    assign addr_hit      = (addr_q == EVT_ADDR);
    assign in_busy_state = (state != ST_IDLE) && (state != ST_RX);
    assign start         = (state == ST_IDLE) && frame_rise && addr_hit;

    // Bytes of a matching frame that arrives while we are still busy are dropped.
    assign rx_drop   = (state == ST_RX) && dv_q && fifo_full;
    assign busy_drop = dv_q && (busy_frame || (frame_rise && addr_hit && in_busy_state));
    assign err_now   = err || rx_drop;

    assign byte_done = (state == ST_TX) && (timer == 32'd0) && half && (bit_cnt == 3'd7);
    assign tx_done   = byte_done && fifo_empty;

    assign fifo_wr    = dv_q && !fifo_full && ((state == ST_RX) || start);
    assign fifo_rd    = byte_done && !fifo_empty;
    assign fifo_flush = (state == ST_RX) && frame_fall && err_now;
    assign hb_reload  = half_bit_cycles(goc_speed) - 32'd1;

    fifo #(
        .WIDTH (8),
        .ADDR_W(ADDR_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (fifo_flush),
        .wr_en  (fifo_wr),
        .wr_data(data_q),
        .rd_en  (fifo_rd),
        .rd_data(fifo_rd_data),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            dv_q   <= 1'b0;
            fv_q   <= 1'b0;
            fv_qq  <= 1'b0;
        end else begin
            addr_q <= ma_addr;
            data_q <= ma_data;
            dv_q   <= ma_data_valid;
            fv_q   <= ma_frame_valid;
            fv_qq  <= fv_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (start) state_next = ST_RX;
            ST_RX: begin
                if (frame_fall) begin
                    if (err_now || (fifo_empty && !fifo_wr))
                        state_next = ST_RESP_REQ;
                    else
                        state_next = ST_TX;
                end
            end
            ST_TX:        if (tx_done) state_next = ST_RESP_REQ;
            ST_RESP_REQ:  if (sl_arb_grant) state_next = ST_RESP_DATA;
            ST_RESP_DATA: state_next = ST_RESP_TAIL;
            ST_RESP_TAIL: state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            err        <= 1'b0;
            busy_frame <= 1'b0;
        end else begin
            if (start) begin
                count <= {7'd0, fifo_wr};
                err   <= 1'b0;
            end else if ((state == ST_RX) && dv_q) begin
                if (count != COUNT_SAT)
                    count <= count + 8'd1;
                if (fifo_full)
                    err <= 1'b1;
            end
            if (!fv_q)
                busy_frame <= 1'b0;
            else if (frame_rise && addr_hit && in_busy_state)
                busy_frame <= 1'b1;
        end
    end

    // Half-bit timer: a new half-bit (and its polarity/speed) is taken whenever timer hits 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= 3'd7;
            half    <= 1'b1;
            timer   <= '0;
            pad     <= 1'b0;
        end else if (state != ST_TX) begin
            bit_cnt <= 3'd7;
            half    <= 1'b1;
            timer   <= '0;
            pad     <= goc_polarity;
        end else if (timer != 32'd0) begin
            timer <= timer - 32'd1;
        end else if (!half) begin
            half  <= 1'b1;
            pad   <= shreg[7] ? goc_polarity : ~goc_polarity;
            timer <= hb_reload;
        end else if (bit_cnt != 3'd7) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            half    <= 1'b0;
            pad     <= shreg[6] ? ~goc_polarity : goc_polarity;
            timer   <= hb_reload;
        end else if (!fifo_empty) begin
            shreg   <= fifo_rd_data;
            bit_cnt <= 3'd0;
            half    <= 1'b0;
            pad     <= fifo_rd_data[7] ? ~goc_polarity : goc_polarity;
            timer   <= hb_reload;
        end else begin
            pad <= goc_polarity;
        end
    end

    always_comb begin
        busy           = (state != ST_IDLE);
        sl_arb_request = 1'b0;
        sl_addr        = '0;
        sl_data        = '0;
        sl_tail        = '0;
        sl_latch_tail  = 1'b0;
        case (state)
            ST_RESP_REQ:  sl_arb_request = 1'b1;
            ST_RESP_DATA: begin
                sl_arb_request = 1'b1;
                sl_addr        = {1'b1, err ? NAK_CODE : ACK_CODE};
                sl_data        = {1'b1, count};
            end
            ST_RESP_TAIL: begin
                sl_latch_tail = 1'b1;
                sl_tail       = {1'b1, TAIL_CODE};
            end
            default: ;
        endcase
    end

    assign goc_pad     = pad;
    assign sl_overflow = rx_drop || busy_drop;

endmodule

// File: tb/tb_goc_frame_tx.sv
// Self-checking bench for goc_frame_tx: directed scenarios plus random frames
// compared against a behavioural Manchester/response model.
module tb_goc_frame_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ma_addr;
    logic [7:0]  ma_data;
    logic        ma_data_valid;
    logic        ma_frame_valid;
    logic        sl_overflow;
    logic [31:0] goc_speed;
    logic        goc_polarity;
    logic        goc_pad;
    logic        sl_arb_request;
    logic        sl_arb_grant;
    logic [8:0]  sl_addr;
    logic [8:0]  sl_data;
    logic [8:0]  sl_tail;
    logic        sl_latch_tail;
    logic        busy;

    int tests   = 0;
    int fails   = 0;
    int ovf_cnt = 0;

    always #5 clk = ~clk;

    goc_frame_tx dut (
        .clk           (clk),
        .reset         (reset),
        .ma_addr       (ma_addr),
        .ma_data       (ma_data),
        .ma_data_valid (ma_data_valid),
        .ma_frame_valid(ma_frame_valid),
        .sl_overflow   (sl_overflow),
        .goc_speed     (goc_speed),
        .goc_polarity  (goc_polarity),
        .goc_pad       (goc_pad),
        .sl_arb_request(sl_arb_request),
        .sl_arb_grant  (sl_arb_grant),
        .sl_addr       (sl_addr),
        .sl_data       (sl_data),
        .sl_tail       (sl_tail),
        .sl_latch_tail (sl_latch_tail),
        .busy          (busy)
    );

    always @(negedge clk) if (sl_overflow === 1'b1) ovf_cnt++;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where ma_frame_valid was dropped.
    task automatic send_frame(input logic [7:0] addr, input logic [7:0] bytes[$],
                              input int gap, input bit simul_last);
        ma_addr        = addr;
        ma_frame_valid = 1'b1;
        for (int i = 0; i < bytes.size(); i++) begin
            tick(gap);
            ma_data       = bytes[i];
            ma_data_valid = 1'b1;
            if (simul_last && (i == bytes.size() - 1)) begin
                ma_frame_valid = 1'b0;
            end else begin
                tick(1);
                ma_data_valid = 1'b0;
            end
        end
        if (ma_frame_valid) begin
            tick(2);
            ma_frame_valid = 1'b0;
        end
    endtask

    // Reference waveform: every bit is two half-bits of hb cycles; a 1 is light-on then off.
    task automatic check_tx(input string tag, input logic [7:0] bytes[$], input int hb,
                            input logic pol);
        logic exp_q[$];
        int   bad = 0;
        int   first_bad = -1;
        foreach (bytes[b]) begin
            for (int k = 7; k >= 0; k--) begin
                logic first_lvl, second_lvl;
                first_lvl  = bytes[b][k] ? !pol : pol;
                second_lvl = bytes[b][k] ? pol : !pol;
                repeat (hb) exp_q.push_back(first_lvl);
                repeat (hb) exp_q.push_back(second_lvl);
            end
        end
        tick(1);
        ma_data_valid = 1'b0;
        tick(1);
        check({tag, "_pad_before_tx"}, goc_pad, pol);
        foreach (exp_q[s]) begin
            tick(1);
            if (goc_pad !== exp_q[s]) begin
                if (bad == 0) first_bad = s;
                bad++;
            end
        end
        check({tag, "_pad_pattern_bad_samples"}, bad, 0);
        if (bad != 0) $display("  %s first bad pad sample at index %0d", tag, first_bad);
        tick(1);
        check({tag, "_pad_after_tx"}, goc_pad, pol);
        check({tag, "_request_after_tx"}, sl_arb_request, 1'b1);
    endtask

    task automatic respond(input string tag, input logic [7:0] code, input logic [7:0] cnt,
                           input int delay, input logic pol);
        int waited = 0;
        int quiet_bad = 0;
        int held_bad = 0;
        while (sl_arb_request !== 1'b1 && waited < 2000) begin
            tick(1);
            waited++;
            if (goc_pad !== pol) quiet_bad++;
        end
        check({tag, "_request_seen"}, sl_arb_request, 1'b1);
        check({tag, "_pad_quiet_before_resp"}, quiet_bad, 0);
        if (sl_arb_request === 1'b1) begin
            for (int i = 0; i < delay; i++) begin
                if (sl_arb_request !== 1'b1 || sl_addr !== 9'h0 || sl_data !== 9'h0 ||
                    sl_tail !== 9'h0 || sl_latch_tail !== 1'b0)
                    held_bad++;
                tick(1);
            end
            check({tag, "_held_until_grant"}, held_bad, 0);
            sl_arb_grant = 1'b1;
            tick(1);
            sl_arb_grant = 1'b0;
            check({tag, "_sl_addr"}, sl_addr, {1'b1, code});
            check({tag, "_sl_data"}, sl_data, {1'b1, cnt});
            tick(1);
            check({tag, "_sl_tail"}, sl_tail, 9'h100);
            check({tag, "_latch_tail"}, sl_latch_tail, 1'b1);
            check({tag, "_request_dropped"}, sl_arb_request, 1'b0);
            check({tag, "_addr_cleared"}, sl_addr, 9'h0);
            tick(1);
            check({tag, "_idle_after_resp"}, busy, 1'b0);
        end
    endtask

    task automatic expect_silence(input string tag, input int cycles, input logic pol);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            tick(1);
            if (sl_arb_request !== 1'b0 || busy !== 1'b0 || sl_addr !== 9'h0 ||
                sl_data !== 9'h0 || sl_latch_tail !== 1'b0 || goc_pad !== pol)
                bad++;
        end
        check({tag, "_silent_cycles_bad"}, bad, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] q2[$];
        int         ovf0;
        int         spd;

        reset          = 1'b1;
        ma_addr        = 8'h00;
        ma_data        = 8'h00;
        ma_data_valid  = 1'b0;
        ma_frame_valid = 1'b0;
        goc_speed      = 32'd4;
        goc_polarity   = 1'b0;
        sl_arb_grant   = 1'b0;
        tick(3);
        check("reset_pad", goc_pad, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_request", sl_arb_request, 1'b0);
        check("reset_sl_addr", sl_addr, 9'h0);
        check("reset_sl_data", sl_data, 9'h0);
        check("reset_sl_tail", {sl_latch_tail, sl_tail}, 10'h0);
        check("reset_overflow", sl_overflow, 1'b0);
        reset = 1'b0;
        tick(2);

        // Grant without a preceding request must be ignored.
        sl_arb_grant = 1'b1;
        tick(1);
        sl_arb_grant = 1'b0;
        check("stray_grant_addr", sl_addr, 9'h0);
        tick(1);
        check("stray_grant_busy", busy, 1'b0);

        // Single byte, last strobe coincident with frame end.
        q = {};
        q.push_back(8'hA5);
        send_frame(8'h67, q, 2, 1'b1);
        check_tx("single", q, 4, 1'b0);
        respond("single", 8'h00, 8'd1, 0, 1'b0);

        // Full buffer, inverted polarity, fastest speed.
        goc_speed    = 32'd1;
        goc_polarity = 1'b1;
        tick(2);
        q = {};
        for (int i = 0; i < 64; i++) q.push_back(8'(i));
        send_frame(8'h67, q, 1, 1'b0);
        check_tx("full", q, 1, 1'b1);
        respond("full", 8'h00, 8'd64, 1, 1'b1);

        // Overflow: 65 bytes -> one drop, nothing transmitted, NAK.
        q = {};
        for (int i = 0; i < 65; i++) q.push_back(8'($urandom));
        ovf0 = ovf_cnt;
        send_frame(8'h67, q, 1, 1'b0);
        respond("overflow", 8'h01, 8'd64, 3, 1'b1);
        check("overflow_pulses", ovf_cnt - ovf0, 1);

        // Wrong address.
        goc_speed    = 32'd3;
        goc_polarity = 1'b0;
        tick(2);
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
        ovf0 = ovf_cnt;
        send_frame(8'h65, q, 1, 1'b0);
        expect_silence("wrong_addr", 60, 1'b0);
        check("wrong_addr_overflow", ovf_cnt - ovf0, 0);

        // Second 'g' frame while transmitting is rejected byte by byte.
        q = {};
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
        q2 = {};
        for (int i = 0; i < 4; i++) q2.push_back(8'($urandom));
        ovf0 = ovf_cnt;
        send_frame(8'h67, q, 1, 1'b0);
        fork
            check_tx("busy_tx", q, 3, 1'b0);
            begin
                tick(20);
                send_frame(8'h67, q2, 2, 1'b0);
            end
        join
        respond("busy_tx", 8'h00, 8'd3, 2, 1'b0);
        expect_silence("busy_single_ack", 40, 1'b0);
        check("busy_overflow_pulses", ovf_cnt - ovf0, 4);

        // Empty frame with delayed grant.
        q = {};
        send_frame(8'h67, q, 1, 1'b0);
        respond("empty", 8'h00, 8'd0, 10, 1'b0);

        // Reset in the middle of transmission.
        goc_speed    = 32'd8;
        goc_polarity = 1'b1;
        tick(2);
        q = {};
        q.push_back(8'h3C);
        q.push_back(8'hC3);
        send_frame(8'h67, q, 1, 1'b0);
        tick(40);
        reset = 1'b1;
        tick(1);
        check("midtx_reset_pad", goc_pad, 1'b0);
        check("midtx_reset_busy", busy, 1'b0);
        tick(1);
        reset = 1'b0;
        expect_silence("midtx_reset", 60, 1'b1);

        // Speed 0 behaves as a one-cycle half-bit.
        goc_speed    = 32'd0;
        goc_polarity = 1'b0;
        tick(2);
        q = {};
        q.push_back(8'($urandom));
        send_frame(8'h67, q, 1, 1'b0);
        check_tx("speed0", q, 1, 1'b0);
        respond("speed0", 8'h00, 8'd1, 0, 1'b0);

        // Random frames against the reference model.
        for (int it = 0; it < 6; it++) begin
            int n;
            n            = $urandom_range(1, 6);
            spd          = $urandom_range(0, 3);
            goc_speed    = 32'(spd);
            goc_polarity = 1'($urandom_range(0, 1));
            tick(2);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            send_frame(8'h67, q, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            check_tx($sformatf("rnd%0d", it), q, (spd == 0) ? 1 : spd, goc_polarity);
            respond($sformatf("rnd%0d", it), 8'h00, 8'(n), $urandom_range(0, 5), goc_polarity);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
